// File: rtl/ll_pkg.sv
// Shared types and constants for the lunar lander input front end.
package ll_pkg;

  typedef enum logic [1:0] {
    ALT  = 2'd0,
    VEL  = 2'd1,
    FUEL = 2'd2,
    THR  = 2'd3
  } ll_disp_t;

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    HELD
  } ll_in_state_t;

  localparam logic [4:0]  KEY_W      = 5'd16;
  localparam logic [4:0]  KEY_X      = 5'd17;
  localparam logic [4:0]  KEY_Y      = 5'd18;
  localparam logic [4:0]  KEY_Z      = 5'd19;
  localparam logic [20:0] VALID_MASK = 21'h0F03FF;

  // Index of the highest set bit; only meaningful when exactly one bit is set.
  function automatic logic [4:0] key_index(input logic [20:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 21; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ll_input_if.sv
// Operator-facing bundle: raw keys and enable in, lander commands out.
interface ll_input_if;
  logic [20:0] pb;
  logic        enable;
  logic [15:0] thrust_n;
  logic        thrust_wen;
  logic [1:0]  disp_sel;
  logic        key_strobe;
  logic [4:0]  key_code;

  modport master (
    output pb, enable,
    input  thrust_n, thrust_wen, disp_sel, key_strobe, key_code
  );

  modport slave (
    input  pb, enable,
    output thrust_n, thrust_wen, disp_sel, key_strobe, key_code
  );
endinterface

// File: rtl/ll_sync.sv
// Two-flop synchronizer with synchronous active-high reset.
module ll_sync #(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/ll_input.sv
// Debounces lander pushbuttons into thrust writes and display selects.
//   state | meaning
//   IDLE  | no valid key present
//   DEB   | single key seen, counting stable samples
//   HELD  | key accepted, waiting for full release
module ll_input
  import ll_pkg::*;
#(
  parameter int          DEBOUNCE = 3,
  parameter logic [15:0] THRUST   = 16'h5
) (
  input logic      hz100,
  input logic      reset,
  ll_input_if.slave bus
);
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

  logic [20:0]  s2;
  logic [20:0]  masked;
  logic         single;
  logic [4:0]   key_idx;
  logic         accept;

  ll_in_state_t state, state_n;
  logic [4:0]   cand, cand_n;
  logic [3:0]   cnt, cnt_n;

  logic [15:0]  thrust_q, thrust_d;
  logic         wen_q, wen_d;
  ll_disp_t     disp_q, disp_d;
  logic         strobe_q, strobe_d;
  logic [4:0]   code_q, code_d;

  ll_sync #(.WIDTH(21)) u_sync (
    .clk   (hz100),
    .reset (reset),
    .d     (bus.pb),
    .q     (s2)
  );

  // A chord is indistinguishable from no key: both fail the one-hot test.
  assign masked  = s2 & VALID_MASK;
  assign single  = (masked != '0) && ((masked & (masked - 21'd1)) == '0);
  assign key_idx = key_index(masked);

  always_ff @(posedge hz100) begin
    if (reset) begin
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      thrust_q <= THRUST;
      wen_q    <= 1'b0;
      disp_q   <= ALT;
      strobe_q <= 1'b0;
      code_q   <= '0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      cnt      <= cnt_n;
      thrust_q <= thrust_d;
      wen_q    <= wen_d;
      disp_q   <= disp_d;
      strobe_q <= strobe_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (single) begin
          if (DEB_MAX == 4'd1) begin
            accept  = 1'b1;
            state_n = HELD;
          end else begin
            state_n = DEB;
            cand_n  = key_idx;
            cnt_n   = 4'd1;
          end
        end
      end
      DEB: begin
        if (!single) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (key_idx != cand) begin
          cand_n = key_idx;
          cnt_n  = 4'd1;
        end else if (cnt + 4'd1 == DEB_MAX) begin
          accept  = 1'b1;
          state_n = HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      HELD: begin
        if (masked == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    thrust_d = thrust_q;
    wen_d    = 1'b0;
    disp_d   = disp_q;
    strobe_d = 1'b0;
    code_d   = code_q;
    if (accept) begin
      strobe_d = 1'b1;
      code_d   = key_idx;
      if (key_idx < 5'd10) begin
        if (bus.enable) begin
          thrust_d = {12'h000, key_idx[3:0]};
          wen_d    = 1'b1;
        end
      end else begin
        unique case (key_idx)
          KEY_Z:   disp_d = ALT;
          KEY_Y:   disp_d = VEL;
          KEY_X:   disp_d = FUEL;
          KEY_W:   disp_d = THR;
          default: disp_d = disp_q;
        endcase
      end
    end
  end

  assign bus.thrust_n   = thrust_q;
  assign bus.thrust_wen = wen_q;
  assign bus.disp_sel   = disp_q;
  assign bus.key_strobe = strobe_q;
  assign bus.key_code   = code_q;
endmodule

// File: tb/tb_ll_input.sv
// Directed bench for ll_input: latency, debounce restart, chords, enable, display select, reset.
module tb_ll_input;
  logic hz100;
  logic reset;
  int   checks;
  int   errors;

  ll_input_if bus();

  ll_input #(.DEBOUNCE(3), .THRUST(16'h5)) dut (
    .hz100 (hz100),
    .reset (reset),
    .bus   (bus)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  // Advance n edges, sampling 1 time unit after each, and tally pulses.
  task automatic run(input int n, output int ns, output int nw, output int ncons);
    logic prev;
    ns = 0; nw = 0; ncons = 0; prev = 1'b0;
    repeat (n) begin
      @(posedge hz100); #1;
      if (bus.key_strobe) ns++;
      if (bus.thrust_wen) nw++;
      if ((bus.key_strobe || bus.thrust_wen) && prev) ncons++;
      prev = bus.key_strobe || bus.thrust_wen;
    end
  endtask

  task automatic test_reset();
    int ns, nw, nc;
    reset = 1'b1; bus.pb = '0; bus.enable = 1'b1;
    run(3, ns, nw, nc);
    reset = 1'b0;
    run(10, ns, nw, nc);
    checks++; if (ns !== 0) begin errors++; $display("FAIL reset_strobes got %0d want 0", ns); end
    checks++; if (nw !== 0) begin errors++; $display("FAIL reset_wen got %0d want 0", nw); end
    checks++; if (bus.thrust_n !== 16'h0005) begin errors++; $display("FAIL reset_thrust got %h want 0005", bus.thrust_n); end
    checks++; if (bus.disp_sel !== 2'd0) begin errors++; $display("FAIL reset_disp got %0d want 0", bus.disp_sel); end
    checks++; if (bus.key_code !== 5'd0) begin errors++; $display("FAIL reset_code got %0d want 0", bus.key_code); end
  endtask

  task automatic test_latency();
    int ns, nw, nc;
    bus.pb = 21'd1 << 7;
    for (int i = 0; i < 4; i++) begin
      run(1, ns, nw, nc);
      checks++; if (ns !== 0 || nw !== 0) begin errors++; $display("FAIL early_pulse edge %0d got s=%0d w=%0d want 0", i, ns, nw); end
    end
    run(1, ns, nw, nc);
    checks++; if (bus.key_strobe !== 1'b1) begin errors++; $display("FAIL lat_strobe got %b want 1", bus.key_strobe); end
    checks++; if (bus.thrust_wen !== 1'b1) begin errors++; $display("FAIL lat_wen got %b want 1", bus.thrust_wen); end
    checks++; if (bus.thrust_n !== 16'h0007) begin errors++; $display("FAIL lat_thrust got %h want 0007", bus.thrust_n); end
    checks++; if (bus.key_code !== 5'd7) begin errors++; $display("FAIL lat_code got %0d want 7", bus.key_code); end
    run(10, ns, nw, nc);
    checks++; if (ns !== 0 || nw !== 0) begin errors++; $display("FAIL held_repeat got s=%0d w=%0d want 0", ns, nw); end
    bus.pb = '0;
    run(5, ns, nw, nc);
  endtask

  task automatic test_debounce_restart();
    int ns, nw, nc;
    bus.pb = 21'd1 << 3;
    run(2, ns, nw, nc);
    bus.pb = '0;
    run(8, ns, nw, nc);
    checks++; if (ns !== 0) begin errors++; $display("FAIL short_pulse got %0d strobes want 0", ns); end
    checks++; if (bus.thrust_n !== 16'h0007) begin errors++; $display("FAIL short_thrust got %h want 0007", bus.thrust_n); end
    bus.pb = 21'd1 << 3;
    run(1, ns, nw, nc);
    bus.pb = 21'd1 << 4;
    run(12, ns, nw, nc);
    checks++; if (ns !== 1 || nw !== 1 || nc !== 0) begin errors++; $display("FAIL restart_count got s=%0d w=%0d c=%0d want 1 1 0", ns, nw, nc); end
    checks++; if (bus.key_code !== 5'd4) begin errors++; $display("FAIL restart_code got %0d want 4", bus.key_code); end
    checks++; if (bus.thrust_n !== 16'h0004) begin errors++; $display("FAIL restart_thrust got %h want 0004", bus.thrust_n); end
    bus.pb = '0;
    run(5, ns, nw, nc);
  endtask

  task automatic test_chord();
    int ns, nw, nc;
    bus.pb = (21'd1 << 2) | (21'd1 << 5);
    run(10, ns, nw, nc);
    checks++; if (ns !== 0) begin errors++; $display("FAIL chord got %0d strobes want 0", ns); end
    bus.pb = '0;
    run(4, ns, nw, nc);
    bus.pb = 21'd1 << 9;
    run(8, ns, nw, nc);
    checks++; if (ns !== 1) begin errors++; $display("FAIL key9 got %0d strobes want 1", ns); end
    bus.pb = (21'd1 << 9) | (21'd1 << 1);
    run(8, ns, nw, nc);
    checks++; if (ns !== 0) begin errors++; $display("FAIL chord_held got %0d strobes want 0", ns); end
    bus.pb = '0;
    run(8, ns, nw, nc);
    checks++; if (ns !== 0) begin errors++; $display("FAIL chord_release got %0d strobes want 0", ns); end
    checks++; if (bus.key_code !== 5'd9 || bus.thrust_n !== 16'h0009) begin errors++; $display("FAIL chord_final got code=%0d thr=%h want 9 0009", bus.key_code, bus.thrust_n); end
  endtask

  task automatic test_enable();
    int ns, nw, nc;
    bus.enable = 1'b0;
    bus.pb = 21'd1 << 8;
    run(8, ns, nw, nc);
    checks++; if (ns !== 1 || nw !== 0) begin errors++; $display("FAIL dis_pulses got s=%0d w=%0d want 1 0", ns, nw); end
    checks++; if (bus.thrust_n !== 16'h0009 || bus.key_code !== 5'd8) begin errors++; $display("FAIL dis_state got thr=%h code=%0d want 0009 8", bus.thrust_n, bus.key_code); end
    bus.pb = '0;
    run(4, ns, nw, nc);
    bus.pb = 21'd1 << 18;
    run(8, ns, nw, nc);
    checks++; if (ns !== 1 || nw !== 0 || bus.disp_sel !== 2'd1) begin errors++; $display("FAIL key_y got s=%0d w=%0d disp=%0d want 1 0 1", ns, nw, bus.disp_sel); end
    bus.pb = '0;
    bus.enable = 1'b1;
    run(4, ns, nw, nc);
  endtask

  task automatic test_disp();
    int ns, nw, nc;
    int keys [3];
    logic [1:0] want [3];
    keys = '{19, 16, 17};
    want = '{2'd0, 2'd3, 2'd2};
    for (int i = 0; i < 3; i++) begin
      bus.pb = 21'd1 << keys[i];
      run(8, ns, nw, nc);
      checks++; if (bus.disp_sel !== want[i] || ns !== 1 || nw !== 0) begin errors++; $display("FAIL disp_key%0d got disp=%0d s=%0d w=%0d want %0d 1 0", keys[i], bus.disp_sel, ns, nw, want[i]); end
      bus.pb = '0;
      run(5, ns, nw, nc);
    end
  endtask

  task automatic test_reset_mid();
    int ns, nw, nc;
    bus.pb = 21'd1 << 6;
    run(3, ns, nw, nc);
    reset = 1'b1;
    bus.pb = '0;
    run(2, ns, nw, nc);
    checks++; if (ns !== 0) begin errors++; $display("FAIL mid_strobe got %0d want 0", ns); end
    checks++; if (bus.thrust_n !== 16'h0005 || bus.disp_sel !== 2'd0 || bus.key_code !== 5'd0) begin errors++; $display("FAIL mid_outputs got thr=%h disp=%0d code=%0d want 0005 0 0", bus.thrust_n, bus.disp_sel, bus.key_code); end
    reset = 1'b0;
    run(8, ns, nw, nc);
    checks++; if (ns !== 0) begin errors++; $display("FAIL post_reset got %0d strobes want 0", ns); end
    // Key held across reset must go through the full debounce again.
    reset = 1'b1;
    bus.pb = 21'd1 << 6;
    run(2, ns, nw, nc);
    reset = 1'b0;
    run(4, ns, nw, nc);
    checks++; if (ns !== 0) begin errors++; $display("FAIL redeb_early got %0d strobes want 0", ns); end
    run(1, ns, nw, nc);
    checks++; if (bus.key_strobe !== 1'b1 || bus.thrust_n !== 16'h0006) begin errors++; $display("FAIL redeb_accept got s=%b thr=%h want 1 0006", bus.key_strobe, bus.thrust_n); end
    bus.pb = '0;
    run(4, ns, nw, nc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.pb = '0;
    bus.enable = 1'b1;
    test_reset();
    test_latency();
    test_debounce_restart();
    test_chord();
    test_enable();
    test_disp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
